signal_move_sched: RTL and testbench
====================================

Name: signal_move_sched

Overview:
- Round-robin scheduler that shares one signal_move converter (12-bit two's complement to offset binary) among NCH free-running ADC sample sources.
- Each source has a 1-deep holding register.
- The scheduler grants one pending channel per cycle and feeds it through the shared converter.
- Results leave on a channel-tagged valid/ready output stream toward the downstream packer, with sticky per-channel overrun flags.

Parameters:
- NCH, 4, number of sample sources (2..8).
- W, 12, sample width; fixed by the signal_move datapath.
- CW, 3, channel tag width; must satisfy 2^CW >= NCH.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- ch_en  in  NCH  per-channel enable; a disabled channel ignores strobes and is never granted.
- smp_stb  in  NCH  per-channel one-cycle sample strobe; no backpressure.
- smp_data  in  NCH*W  packed signed samples; channel i occupies bits [i*W+W-1 : i*W].
- ovr_clr  in  1  clears all overrun flags.
- out_valid  out  1  converted sample available.
- out_ready  in  1  downstream accepts.
- out_data  out  W  offset-binary sample.
- out_ch  out  CW  source channel of out_data.
- ovr_flag  out  NCH  sticky per-channel overrun.
- busy  out  1  any holding register or the pipeline is occupied.

Behaviour:
- Reset (asynchronous, immediate): out_valid=0, out_data=0, out_ch=0, ovr_flag=0, busy=0, all holding registers empty, round-robin pointer=0.
- Capture:
  - smp_stb[i] with ch_en[i]=1 loads the holding register and sets its pending bit.
  - If the pending bit is already set and the slot is not granted this cycle, the new sample overwrites the held one and ovr_flag[i] sets.
  - Strobe in the same cycle the slot is granted: the granted sample moves on, the new sample is held, no overrun.
- Arbitration:
  - One grant per cycle, only when stage 1 is empty or is being drained this cycle (out_ready & out_valid).
  - Search starts at the pointer. After a grant to channel k, the pointer becomes (k+1) mod NCH.
  - No pending channel: no grant, pointer unchanged.
- Pipeline:
  - Stage 0 is the grant and mux (combinational). Stage 1 registers the signal_move result plus the tag.
  - Latency: strobe in cycle t, earliest out_valid in cycle t+2.
  - Throughput is one sample per cycle while out_ready=1.
- Conversion (shared converter):
  - out_data = (x + 12'h7FF) mod 4096 for x != 12'h800; x = 12'h800 yields 12'h7FF.
  - Examples: 0 -> 7FF, 1 -> 800, 7FF -> FFE, FFF(-1) -> 7FE.
- Handshake:
  - out_data and out_ch hold stable while out_valid=1 and out_ready=0.
  - out_valid deasserts only after a transfer with no refill.
- Channel disable:
  - ch_en[i] falling clears the pending bit of channel i.
  - A sample of channel i already in stage 1 still completes.
- Overrun flags:
  - ovr_clr clears all flags.
  - If ovr_clr and a new overrun occur in the same cycle on the same channel, the flag ends set.
- busy = OR of pending bits | out_valid.

Test Plan:
- Reset then single strobe: ch0 = 12'h001, out_ready=1 -> out_valid two cycles later, out_data=12'h800, out_ch=0; then idle, busy=0.
- Conversion sweep on ch1: 000, 7FF, 800, FFF -> 7FF, FFE, 7FF, 7FE in order, tag 1.
- Simultaneous strobes on all 4 channels, out_ready=1 -> outputs in tag order 0,1,2,3 on consecutive cycles. Repeat with pointer at 2 -> order 2,3,0,1.
- Backpressure: out_ready=0 for 5 cycles with ch0 strobing every cycle -> out_data held stable, ovr_flag[0]=1 while other flags stay 0; ovr_clr -> all 0.
- Disabled channel: ch_en=4'b1011, strobe ch2 -> no output, ovr_flag[2] stays 0. Also drop ch_en[3] while ch3 is pending -> its sample is discarded.
- Async reset asserted mid-stream with out_valid=1 -> out_valid=0 and ovr_flag=0 immediately, without waiting for a clock edge; after release the first strobe converts correctly.

Source files
------------

// File: rtl/signal_move_sched.sv
// signal_move_sched
// Shares one signal_move converter (two's complement -> offset binary)
// among NCH free-running sample sources. Every source owns a 1-deep holding
// slot. A round-robin arbiter picks one pending slot per cycle, and that
// sample is converted into a single output register with valid/ready
// handshake and a channel tag. Per-channel sticky overrun flags record
// samples that were overwritten before they were granted.
module signal_move_sched #(
  parameter int NCH = 4,
  parameter int W   = 12,
  parameter int CW  = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NCH-1:0]     ch_en,
  input  logic [NCH-1:0]     smp_stb,
  input  logic [NCH*W-1:0]   smp_data,
  input  logic               ovr_clr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W-1:0]       out_data,
  output logic [CW-1:0]      out_ch,
  output logic [NCH-1:0]     ovr_flag,
  output logic               busy
);

  localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  // Offset-binary conversion. The most negative code has no symmetric
  // partner, so it is pinned to the mid-scale code instead of wrapping.
  function automatic logic [W-1:0] sig_move(input logic signed [W-1:0] x);
    logic [W-1:0] sum;
    sum = $unsigned(x) + MAX_POS;
    if ($unsigned(x) == MIN_NEG) begin
      return MAX_POS;
    end
    return sum;
  endfunction

  // Holding slots (stage 0 storage) and control state
  logic signed [W-1:0] r_hold_p0 [NCH];
  logic [NCH-1:0]      r_pend_p0;
  logic [NCH-1:0]      r_ovr;
  logic [CW-1:0]       r_ptr;

  // Output register (stage 1)
  logic                r_vld_p1;
  logic [W-1:0]        r_data_p1;
  logic [CW-1:0]       r_ch_p1;

  // Combinational grant / mux signals
  logic signed [W-1:0] w_smp [NCH];
  logic [NCH-1:0]      w_cap;
  logic [NCH-1:0]      w_req;
  logic                w_can_grant;
  logic                w_gnt_vld;
  logic [CW-1:0]       w_gnt_idx;
  logic [NCH-1:0]      w_gnt_oh;
  logic signed [W-1:0] w_gnt_data;
  logic [CW-1:0]       w_ptr_nxt;
  logic [NCH-1:0]      w_ovr_set;
  logic [NCH-1:0]      w_pend_nxt;

  // A disabled channel neither captures nor competes for the converter.
  assign w_cap       = smp_stb & ch_en;
  assign w_req       = r_pend_p0 & ch_en;
  assign w_can_grant = !r_vld_p1 || out_ready;

  // Unpack the flat sample bus into per-channel signed samples.
  always_comb begin
    for (int j = 0; j < NCH; j++) begin
      w_smp[j] = smp_data[j*W +: W];
    end
  end

  // ---- stage 0: round-robin grant starting at the pointer, then mux ----
  always_comb begin
    int idx;
    w_gnt_vld  = 1'b0;
    w_gnt_idx  = '0;
    w_gnt_oh   = '0;
    w_gnt_data = '0;
    idx        = 0;
    if (w_can_grant) begin
      for (int off = 0; off < NCH; off++) begin
        idx = int'(r_ptr) + off;
        if (idx >= NCH) begin
          idx = idx - NCH;
        end
        if (!w_gnt_vld && w_req[idx]) begin
          w_gnt_vld = 1'b1;
          w_gnt_idx = CW'(idx);
        end
      end
    end
    for (int j = 0; j < NCH; j++) begin
      if (w_gnt_vld && (w_gnt_idx == CW'(j))) begin
        w_gnt_oh[j] = 1'b1;
        w_gnt_data  = r_hold_p0[j];
      end
    end
  end

  // Pointer moves to the channel after the granted one, wrapping at NCH.
  always_comb begin
    w_ptr_nxt = r_ptr;
    if (w_gnt_vld) begin
      if (w_gnt_idx == CW'(NCH-1)) begin
        w_ptr_nxt = '0;
      end else begin
        w_ptr_nxt = w_gnt_idx + CW'(1);
      end
    end
  end

  // Slot bookkeeping: a strobe into a still-pending, ungranted slot is an
  // overrun; a strobe into a slot granted this cycle simply refills it.
  // Dropping the enable empties the slot.
  always_comb begin
    w_ovr_set  = w_cap & w_req & ~w_gnt_oh;
    w_pend_nxt = ch_en & (w_cap | (r_pend_p0 & ~w_gnt_oh));
  end

  // Control state: pending bits, overrun flags, pointer and output stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend_p0 <= '0;
      r_ovr     <= '0;
      r_ptr     <= '0;
      r_vld_p1  <= 1'b0;
      r_data_p1 <= '0;
      r_ch_p1   <= '0;
    end else begin
      r_pend_p0 <= w_pend_nxt;
      // A new overrun wins over a simultaneous clear.
      r_ovr     <= (r_ovr & ~{NCH{ovr_clr}}) | w_ovr_set;
      r_ptr     <= w_ptr_nxt;
      // ---- stage 1: converted sample plus tag; held while stalled ----
      if (w_can_grant) begin
        r_vld_p1 <= w_gnt_vld;
        if (w_gnt_vld) begin
          r_data_p1 <= sig_move(w_gnt_data);
          r_ch_p1   <= w_gnt_idx;
        end
      end
    end
  end

  // Sample payload of the holding slots; emptiness is tracked by r_pend_p0.
  always_ff @(posedge clk) begin
    for (int j = 0; j < NCH; j++) begin
      if (w_cap[j]) begin
        r_hold_p0[j] <= w_smp[j];
      end
    end
  end

  assign out_valid = r_vld_p1;
  assign out_data  = r_data_p1;
  assign out_ch    = r_ch_p1;
  assign ovr_flag  = r_ovr;
  assign busy      = (|r_pend_p0) | r_vld_p1;

endmodule

// File: tb/tb_signal_move_sched.sv
// Bench for signal_move_sched: directed scenarios plus randomized traffic,
// all compared cycle by cycle against a slot/queue-level reference model.
module tb_signal_move_sched;
  localparam int NCH = 4;
  localparam int W   = 12;
  localparam int CW  = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [NCH-1:0]   ch_en;
  logic [NCH-1:0]   smp_stb;
  logic [NCH*W-1:0] smp_data;
  logic             ovr_clr;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic [CW-1:0]    out_ch;
  logic [NCH-1:0]   ovr_flag;
  logic             busy;

  signal_move_sched #(.NCH(NCH), .W(W), .CW(CW)) dut (
    .clk(clk), .rst(rst), .ch_en(ch_en), .smp_stb(smp_stb),
    .smp_data(smp_data), .ovr_clr(ovr_clr), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch),
    .ovr_flag(ovr_flag), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: slots, overrun flags, pointer, one output register.
  logic [NCH-1:0] m_pend;
  logic [NCH-1:0] m_ovr;
  logic [W-1:0]   m_hold [NCH];
  int             m_ptr;
  logic           m_vld;
  logic [W-1:0]   m_data;
  int             m_ch;

  function automatic logic [W-1:0] conv(input logic [W-1:0] x);
    int v;
    if (x == 12'h800) return 12'h7FF;
    v = (int'(x) + 2047) % 4096;
    return v[W-1:0];
  endfunction

  task automatic model_reset();
    m_pend = '0; m_ovr = '0; m_ptr = 0; m_vld = 1'b0; m_data = '0; m_ch = 0;
    for (int i = 0; i < NCH; i++) m_hold[i] = '0;
  endtask

  task automatic model_update();
    int g;
    g = -1;
    if (!m_vld || out_ready) begin
      for (int off = 0; off < NCH; off++) begin
        int idx;
        idx = (m_ptr + off) % NCH;
        if (g < 0 && m_pend[idx] && ch_en[idx]) g = idx;
      end
      m_vld = (g >= 0);
      if (g >= 0) begin
        m_data = conv(m_hold[g]);
        m_ch   = g;
        m_ptr  = (g + 1) % NCH;
      end
    end
    for (int i = 0; i < NCH; i++) begin
      if (ovr_clr) m_ovr[i] = 1'b0;
      if (!ch_en[i]) begin
        m_pend[i] = 1'b0;
      end else if (smp_stb[i]) begin
        if (m_pend[i] && g != i) m_ovr[i] = 1'b1;
        m_hold[i] = smp_data[i*W +: W];
        m_pend[i] = 1'b1;
      end else if (g == i) begin
        m_pend[i] = 1'b0;
      end
    end
  endtask

  task automatic model_check();
    chk("valid", 32'(out_valid), 32'(m_vld));
    chk("data",  32'(out_data),  32'(m_data));
    chk("ch",    32'(out_ch),    32'(m_ch));
    chk("ovr",   32'(ovr_flag),  32'(m_ovr));
    chk("busy",  32'(busy),      32'((|m_pend) | m_vld));
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    model_check();
  endtask

  task automatic set_smp(input int ch, input logic [W-1:0] v);
    smp_data[ch*W +: W] = v;
  endtask

  logic [W-1:0] sweep_in  [4] = '{12'h000, 12'h7FF, 12'h800, 12'hFFF};
  logic [W-1:0] sweep_exp [4] = '{12'h7FF, 12'hFFE, 12'h7FF, 12'h7FE};
  int ord_a [4] = '{2, 3, 0, 1};
  int ord_b [4] = '{0, 1, 2, 3};
  logic [W-1:0] held;

  initial begin
    rst = 1'b1; ch_en = '1; smp_stb = '0; smp_data = '0; ovr_clr = 1'b0; out_ready = 1'b1;
    model_reset();
    #12;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data",  32'(out_data),  0);
    chk("rst_ch",    32'(out_ch),    0);
    chk("rst_ovr",   32'(ovr_flag),  0);
    chk("rst_busy",  32'(busy),      0);
    rst = 1'b0;

    // single strobe on ch0
    set_smp(0, 12'h001); smp_stb = 4'b0001;
    step();
    smp_stb = '0;
    step();
    chk("t1_valid", 32'(out_valid), 1);
    chk("t1_data",  32'(out_data),  32'h800);
    chk("t1_ch",    32'(out_ch),    0);
    step();
    chk("t1_busy",  32'(busy), 0);

    // conversion sweep on ch1
    for (int k = 0; k < 4; k++) begin
      set_smp(1, sweep_in[k]); smp_stb = 4'b0010;
      step();
      smp_stb = '0;
      step();
      chk("sweep_data", 32'(out_data), 32'(sweep_exp[k]));
      chk("sweep_ch",   32'(out_ch),   1);
    end
    step();

    // all channels at once, pointer at 2
    for (int i = 0; i < NCH; i++) set_smp(i, 12'($urandom));
    smp_stb = '1;
    step();
    smp_stb = '0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("order_a", 32'(out_ch), 32'(ord_a[k]));
    end
    step();
    // move pointer to 0 via a lone ch3 grant
    smp_stb = 4'b1000;
    step();
    smp_stb = '0;
    step(); step();
    for (int i = 0; i < NCH; i++) set_smp(i, 12'($urandom));
    smp_stb = '1;
    step();
    smp_stb = '0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("order_b", 32'(out_ch), 32'(ord_b[k]));
    end
    step();

    // backpressure with ch0 strobing every cycle
    out_ready = 1'b0; smp_stb = 4'b0001;
    held = '0;
    for (int k = 0; k < 5; k++) begin
      set_smp(0, 12'($urandom));
      step();
      if (k == 1) held = out_data;
      if (k >= 2) chk("bp_hold", 32'(out_data), 32'(held));
    end
    chk("bp_ovr", 32'(ovr_flag), 32'h1);
    smp_stb = '0; ovr_clr = 1'b1;
    step();
    chk("bp_clr", 32'(ovr_flag), 0);
    ovr_clr = 1'b0; out_ready = 1'b1;
    step(); step(); step();
    chk("bp_idle", 32'(busy), 0);

    // disabled channel 2 ignores strobes
    ch_en = 4'b1011; smp_stb = 4'b0100;
    step(); step();
    smp_stb = '0;
    step(); step();
    chk("dis_valid", 32'(out_valid), 0);
    chk("dis_ovr2",  32'(ovr_flag[2]), 0);
    // ch3 pending, then disabled: its sample is discarded
    ch_en = '1; out_ready = 1'b0; smp_stb = 4'b0001;
    step();
    smp_stb = 4'b1000;
    step();
    smp_stb = '0;
    step();
    chk("drop_busy", 32'(busy), 1);
    ch_en = 4'b0111;
    step();
    ch_en = '1; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("drop_no_ch3", 32'(out_valid && out_ch == 3'd3), 0);
    end
    chk("drop_idle", 32'(busy), 0);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NCH; i++) begin
        ch_en[i] = ($urandom_range(0, 7) != 0);
        set_smp(i, 12'($urandom));
      end
      smp_stb   = 4'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      ovr_clr   = ($urandom_range(0, 19) == 0);
      step();
    end

    // async reset mid-stream
    ch_en = '1; ovr_clr = 1'b0; out_ready = 1'b0; smp_stb = 4'b0001;
    step(); step(); step();
    chk("pre_rst_valid", 32'(out_valid), 1);
    chk("pre_rst_ovr",   32'(ovr_flag[0]), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_ovr",   32'(ovr_flag),  0);
    chk("arst_busy",  32'(busy),      0);
    #1;
    rst = 1'b0; smp_stb = '0; out_ready = 1'b1;
    model_reset();
    set_smp(2, 12'h7FF); smp_stb = 4'b0100;
    step();
    smp_stb = '0;
    step();
    chk("post_valid", 32'(out_valid), 1);
    chk("post_data",  32'(out_data),  32'hFFE);
    chk("post_ch",    32'(out_ch),    2);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
